alu_req_master: RTL and testbench

//  Initiator side of the 4-bit ALU operand/select/result interface.
//  - Accepts tagged commands from an upstream valid/ready port and drives alu_a/alu_b/alu_sel.
//  - Captures alu_result after the fixed ALU latency into a response FIFO.
//  - Returns results, in order, with their tag on a downstream valid/ready port.
//  - Pipelined: one issue per cycle; credit-limited so a response slot always exists.

---
 rtl/alu_req_master.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_req_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_master.sv
// -----------------------------------------------------------------------------
// alu_req_master
// Initiator side of the 4-bit ALU operand/select/result interface. Tagged
// commands are accepted on an upstream valid/ready port and driven onto
// alu_a/alu_b/alu_sel. After the fixed ALU latency, alu_result is captured
// into a show-ahead response FIFO. Results are returned in issue order,
// together with their tag, on a downstream valid/ready port.
// Issue is credit-limited, so every in-flight op always has a FIFO slot.
//
// Optional feature: define ALU_REQ_CHECK_EN to enable the capture-stage
// reference model that drives the sticky chk_err flag. When the macro is
// undefined, chk_err is tied to 0.
//
// Ports
//   clk                     clock, all logic on posedge
//   rst                     synchronous reset, active-low
//   cmd_valid/ready         upstream handshake
//   cmd_a/b/op/tag          operands, ALU select code, opaque tag
//   alu_rst                 active-high reset to the ALU (= ~rst)
//   alu_a/b/sel             registered ALU inputs
//   alu_result              registered ALU result
//   rsp_valid/ready         downstream handshake
//   rsp_result/tag          captured result and its tag
//   chk_err                 sticky reference-model mismatch flag
// -----------------------------------------------------------------------------

// Overflow checker for the response FIFO.
module alu_req_master_chk (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic full
);
    // A capture must never land on a full FIFO; the credit scheme forbids it.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));
endmodule

module alu_req_master #(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             alu_rst,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [5:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [5:0]       rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             chk_err
);
    localparam int AW  = $clog2(RSP_DEPTH);
    localparam int CW  = AW + 1;
    // Stage 0 is loaded at the issue edge; the last stage marks the capture edge.
    localparam int NST = ALU_LAT + 1;
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(RSP_DEPTH);

    logic                run_r;
    logic [NST-1:0]      pipe_vld_r;
    logic [TAG_W-1:0]    pipe_tag_r [NST];
    logic [CW-1:0]       inflight_r;
    logic [CW-1:0]       wr_ptr_r;
    logic [CW-1:0]       rd_ptr_r;
    logic [5:0]          mem_res_r [RSP_DEPTH];
    logic [TAG_W-1:0]    mem_tag_r [RSP_DEPTH];
    logic                issue_s;
    logic                capture_s;
    logic                pop_s;
    logic                empty_s;
    logic                full_s;
    logic [CW-1:0]       fifo_cnt_s;
    logic [CW:0]         used_s;

`ifdef ALU_REQ_CHECK_EN
    logic [3:0]          pipe_a_r   [NST];
    logic [3:0]          pipe_b_r   [NST];
    logic [2:0]          pipe_sel_r [NST];
    logic                chk_err_r;

    // Golden ALU: operands zero-extended to 6 bits, result mod 64.
    function automatic logic [5:0] alu_ref(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        logic [5:0] ea;
        logic [5:0] eb;
        logic [5:0] r;
        ea = {2'b00, a};
        eb = {2'b00, b};
        case (sel)
            3'b000:  r = ea + eb;
            3'b001:  r = ea | eb;
            3'b010:  r = ea & eb;
            3'b011:  r = ea ^ eb;
            3'b100:  r = ~(ea ^ eb);
            3'b101:  r = ~(ea & eb);
            3'b110:  r = ~(ea | eb);
            3'b111:  r = ea - eb;
            default: r = 6'h00;
        endcase
        return r;
    endfunction
`endif

    assign alu_rst    = ~rst;
    assign issue_s    = cmd_valid && cmd_ready;
    assign capture_s  = pipe_vld_r[NST-1];
    assign pop_s      = rsp_valid && rsp_ready;
    assign empty_s    = (wr_ptr_r == rd_ptr_r);
    assign full_s     = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                        (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign fifo_cnt_s = wr_ptr_r - rd_ptr_r;
    assign used_s     = {1'b0, inflight_r} + {1'b0, fifo_cnt_s};

    // Credit check from registered state only, so a pop frees a slot one cycle later.
    // run_r keeps cmd_ready low while reset is held.
    always_comb begin
        if (run_r && (used_s < DEPTH_C)) begin
            cmd_ready = 1'b1;
        end else begin
            cmd_ready = 1'b0;
        end
    end

    // Show-ahead FIFO head, forced to zero when empty.
    always_comb begin
        rsp_valid = !empty_s;
        if (!empty_s) begin
            rsp_result = mem_res_r[rd_ptr_r[AW-1:0]];
            rsp_tag    = mem_tag_r[rd_ptr_r[AW-1:0]];
        end else begin
            rsp_result = 6'h00;
            rsp_tag    = '0;
        end
    end

    // Issue register, tag pipe and in-flight counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_r      <= 1'b0;
            alu_a      <= 4'h0;
            alu_b      <= 4'h0;
            alu_sel    <= 3'h0;
            pipe_vld_r <= '0;
            inflight_r <= '0;
            for (int i = 0; i < NST; i++) begin
                pipe_tag_r[i] <= '0;
            end
        end else begin
            run_r <= 1'b1;
            if (issue_s) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_op;
            end
            pipe_vld_r    <= {pipe_vld_r[NST-2:0], issue_s};
            pipe_tag_r[0] <= cmd_tag;
            for (int i = 1; i < NST; i++) begin
                pipe_tag_r[i] <= pipe_tag_r[i-1];
            end
            case ({issue_s, capture_s})
                2'b10:   inflight_r <= inflight_r + ONE_C;
                2'b01:   inflight_r <= inflight_r - ONE_C;
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Response FIFO: push on capture, pop on downstream handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_res_r[i] <= 6'h00;
                mem_tag_r[i] <= '0;
            end
        end else begin
            if (capture_s) begin
                mem_res_r[wr_ptr_r[AW-1:0]] <= alu_result;
                mem_tag_r[wr_ptr_r[AW-1:0]] <= pipe_tag_r[NST-1];
                wr_ptr_r                    <= wr_ptr_r + ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
        end
    end

`ifdef ALU_REQ_CHECK_EN
    // Operand pipe alongside the tag pipe, plus the sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            chk_err_r <= 1'b0;
            for (int i = 0; i < NST; i++) begin
                pipe_a_r[i]   <= 4'h0;
                pipe_b_r[i]   <= 4'h0;
                pipe_sel_r[i] <= 3'h0;
            end
        end else begin
            pipe_a_r[0]   <= cmd_a;
            pipe_b_r[0]   <= cmd_b;
            pipe_sel_r[0] <= cmd_op;
            for (int i = 1; i < NST; i++) begin
                pipe_a_r[i]   <= pipe_a_r[i-1];
                pipe_b_r[i]   <= pipe_b_r[i-1];
                pipe_sel_r[i] <= pipe_sel_r[i-1];
            end
            if (capture_s && (alu_result != alu_ref(pipe_a_r[NST-1], pipe_b_r[NST-1],
                                                    pipe_sel_r[NST-1]))) begin
                chk_err_r <= 1'b1;
            end
        end
    end
    assign chk_err = chk_err_r;
`else
    assign chk_err = 1'b0;
`endif

    alu_req_master_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (capture_s),
        .full (full_s)
    );
endmodule

// File: tb/tb_alu_req_master.sv
module tb_alu_req_master;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;
    logic [3:0] cmd_tag;
    logic       alu_rst;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [5:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [5:0] rsp_result;
    logic [3:0] rsp_tag;
    logic       chk_err;

    logic [5:0] corrupt = 6'h00;
    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_pop = 0;
    logic [9:0] exp_q [$];

    alu_req_master dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_rst(alu_rst), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_tag(rsp_tag), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    // Reference ALU: plain integer arithmetic, keep the low 6 bits.
    function automatic logic [5:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] op);
        int x;
        int y;
        int r;
        x = int'(a);
        y = int'(b);
        case (op)
            3'd0:    r = x + y;
            3'd1:    r = x | y;
            3'd2:    r = x & y;
            3'd3:    r = x ^ y;
            3'd4:    r = ~(x ^ y);
            3'd5:    r = ~(x & y);
            3'd6:    r = ~(x | y);
            3'd7:    r = x - y;
            default: r = 0;
        endcase
        return 6'(r & 63);
    endfunction

    // External registered ALU with optional fault injection.
    always @(posedge clk) begin
        alu_result <= alu_rst ? 6'h00 : (ref_alu(alu_a, alu_b, alu_sel) ^ corrupt);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: record accepted commands, compare every popped response.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst !== 1'b1) begin
            exp_q.delete();
        end else begin
            if (cmd_valid && cmd_ready === 1'b1) begin
                exp_q.push_back({ref_alu(cmd_a, cmd_b, cmd_op) ^ corrupt, cmd_tag});
                n_acc++;
            end
            if (rsp_valid === 1'b1 && rsp_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_result", 32'(rsp_result), 32'(e[9:4]));
                    check("rsp_tag", 32'(rsp_tag), 32'(e[3:0]));
                end
            end
        end
    end

    task automatic randomize_cmd();
        cmd_a   = 4'($urandom_range(0, 15));
        cmd_b   = 4'($urandom_range(0, 15));
        cmd_op  = 3'($urandom_range(0, 7));
        cmd_tag = 4'($urandom_range(0, 15));
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] tag);
        bit ok;
        ok = 1'b0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = (cmd_ready === 1'b1);
        end
        if (!ok) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int p0;
        rst = 1'b0; cmd_valid = 1'b1; rsp_ready = 1'b1;
        cmd_a = 4'h7; cmd_b = 4'h9; cmd_op = 3'd0; cmd_tag = 4'h5;

        // 1: reset held with a pending command
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rst_alu_a", 32'(alu_a), 32'd0);
            check("rst_alu_b", 32'(alu_b), 32'd0);
            check("rst_alu_sel", 32'(alu_sel), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_result", 32'(rsp_result), 32'd0);
            check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
            check("rst_chk_err", 32'(chk_err), 32'd0);
            check("rst_alu_rst", 32'(alu_rst), 32'd1);
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("alu_rst_released", 32'(alu_rst), 32'd0);

        // 2: single op, latency
        send(4'd3, 4'd5, 3'b000, 4'd1);
        check("issue_alu_a", 32'(alu_a), 32'd3);
        check("issue_alu_b", 32'(alu_b), 32'd5);
        check("issue_alu_sel", 32'(alu_sel), 32'd0);
        check("lat_valid_e0", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_e1", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_valid_e2", 32'(rsp_valid), 32'd1);
        check("lat_result", 32'(rsp_result), 32'h08);
        check("lat_tag", 32'(rsp_tag), 32'd1);
        drain();

        // 3: boundary operations
        send(4'd3, 4'd5, 3'b111, 4'd2);
        send(4'd0, 4'd0, 3'b100, 4'd3);
        send(4'hF, 4'hF, 3'b000, 4'd4);
        drain();
        check("chk_err_clean", 32'(chk_err), 32'd0);

        // Random traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            randomize_cmd();
            cmd_valid = 1'($urandom_range(0, 1));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b1;
        drain();

        // 4: credit limit with a stalled consumer
        rsp_ready = 1'b0;
        a0 = n_acc;
        cmd_valid = 1'b1;
        repeat (10) begin
            randomize_cmd();
            @(posedge clk); #1;
        end
        check("credit_accepts", 32'(n_acc - a0), 32'd4);
        check("credit_ready_low", 32'(cmd_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("credit_same_cycle_pop", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("credit_after_pop", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        drain();

        // 5: full throughput
        randomize_cmd();
        cmd_valid = 1'b1;
        a0 = n_acc;
        p0 = n_pop;
        repeat (40) begin
            @(posedge clk); #1;
            randomize_cmd();
        end
        cmd_valid = 1'b0;
        check("stream_accepts", 32'(n_acc - a0), 32'd40);
        check("stream_pops", 32'(n_pop - p0), 32'd37);
        drain();

        // 6: reset with 2 in flight and 2 buffered
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        repeat (4) begin
            randomize_cmd();
            @(posedge clk); #1;
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst_alu_a", 32'(alu_a), 32'd0);
        check("midrst_rsp_result", 32'(rsp_result), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        p0 = n_pop;
        send(4'd9, 4'd2, 3'b011, 4'hA);
        drain();
        check("post_rst_rsp_count", 32'(n_pop - p0), 32'd1);

`ifdef ALU_REQ_CHECK_EN
        check("chk_err_before_fault", 32'(chk_err), 32'd0);
        corrupt = 6'h04;
        send(4'd1, 4'd2, 3'b000, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        corrupt = 6'h00;
        drain();
        check("chk_err_set", 32'(chk_err), 32'd1);
        send(4'd6, 4'd1, 3'b010, 4'd7);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("chk_err_sticky", 32'(chk_err), 32'd1);
`else
        check("chk_err_tied", 32'(chk_err), 32'd0);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
